// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: request side (in_*) and result side (out_*).
// The slave modport is the unit itself; master is whoever drives requests and consumes results.
interface imm_extend_pipe_if #(
  parameter int IN_W    = 3,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 3
) ();

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic [1:0]         in_mode;
  logic [SHAMT_W-1:0] in_shamt;

  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_ovf;
  logic               out_neg;

  modport master (
    output in_valid, in_data, in_mode, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_neg
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_shamt, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_neg
  );

endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit: widens an IN_W-bit immediate to OUT_W bits in one of four modes
// and queues the results in a 2-entry in-order output buffer with valid/ready on both sides.
module imm_extend_pipe #(
  parameter int IN_W    = 3,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 3
) (
  input logic              clk,
  input logic              rst,
  imm_extend_pipe_if.slave bus
);

  if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
    $error("imm_extend_pipe: IN_W must satisfy 1 <= IN_W <= OUT_W");
  end

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             ovf;
    logic             neg;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           new_entry;

  logic [OUT_W-1:0] s_ext;
  logic [OUT_W-1:0] shl_res;
  logic             shl_ovf;
  logic [OUT_W-1:0] res;
  logic             res_ovf;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Result computation (purely combinational from the request bus)
  // ---------------------------------------------------------------------------
  assign s_ext = OUT_W'($signed(bus.in_data));

  // Overflow means the shift lost significant bits: shifting back arithmetically
  // must reproduce the sign-extended operand.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    shl_res = '0;
    shl_ovf = 1'b0;
    if (32'(bus.in_shamt) >= OUT_W) begin
      shl_ovf = |s_ext;
    end else begin
      shl_res = s_ext << bus.in_shamt;
      shl_ovf = ($signed(shl_res) >>> bus.in_shamt) != $signed(s_ext);
    end
  end

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (bus.in_mode)
      2'b00:   res = OUT_W'(bus.in_data);
      2'b01:   res = s_ext;
      2'b10: begin
        res     = shl_res;
        res_ovf = shl_ovf;
      end
      default: res = OUT_W'(bus.in_data) << (OUT_W - IN_W);
    endcase
  end

  assign new_entry = '{data: res, ovf: res_ovf, neg: res[OUT_W-1]};

  // ---------------------------------------------------------------------------
  // Output buffer: head register feeds the outputs directly, tail holds the
  // second entry. Head is left untouched when the last entry pops so the
  // outputs keep showing the most recently popped result.
  // ---------------------------------------------------------------------------
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: both buffer slots are reset as well; the outputs must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Ready depends only on buffer occupancy and reset, never on out_ready.
  assign bus.in_ready  = !rst && (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = head_q.data;
  assign bus.out_ovf   = head_q.ovf;
  assign bus.out_neg   = head_q.neg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: an arithmetic reference model with a queue-based
// buffer is compared against the DUT every cycle; directed vectors pin literal results.
module tb_imm_extend_pipe;

  localparam int IN_W    = 3;
  localparam int OUT_W   = 8;
  localparam int SHAMT_W = 3;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             ovf;
  } exp_t;

  typedef struct packed {
    logic [IN_W-1:0]    d;
    logic [1:0]         m;
    logic [SHAMT_W-1:0] sh;
    logic [OUT_W-1:0]   want_data;
    logic               want_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the signed value of the immediate.
  function automatic exp_t model_fn(input logic [IN_W-1:0] d, input logic [1:0] m,
                                    input logic [SHAMT_W-1:0] sh);
    longint s, p, hi, lo;
    exp_t   e;
    s = longint'(d);
    if (d[IN_W-1]) s = s - (longint'(1) << IN_W);
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    e.ovf = 1'b0;
    case (m)
      2'b00: e.data = OUT_W'(longint'(d));
      2'b01: e.data = OUT_W'(s);
      2'b10: begin
        p      = s * (longint'(1) << sh);
        e.data = OUT_W'(p);
        e.ovf  = (p > hi) || (p < lo);
      end
      default: e.data = OUT_W'(longint'(d) * (longint'(1) << (OUT_W - IN_W)));
    endcase
    return e;
  endfunction

  // Every-cycle compare against a queue model of the buffer; the model then
  // applies the push/pop that the coming rising edge will perform.
  exp_t mq[$];
  exp_t last_popped = '0;

  always @(negedge clk) begin
    exp_t head;
    logic want_ready, do_push, do_pop;
    if (rst) begin
      mq.delete();
      last_popped = '0;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_ovf", bus.out_ovf, 0);
      check("rst_out_neg", bus.out_neg, 0);
    end else begin
      want_ready = (mq.size() < 2);
      head       = (mq.size() != 0) ? mq[0] : last_popped;
      check("mdl_in_ready", bus.in_ready, want_ready);
      check("mdl_out_valid", bus.out_valid, mq.size() != 0);
      check("mdl_out_data", bus.out_data, head.data);
      check("mdl_out_ovf", bus.out_ovf, head.ovf);
      check("mdl_out_neg", bus.out_neg, head.data[OUT_W-1]);
      do_pop  = (mq.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && want_ready;
      if (do_pop) last_popped = mq.pop_front();
      if (do_push) mq.push_back(model_fn(bus.in_data, bus.in_mode, bus.in_shamt));
    end
  end

  // Drive one request and hold it until accepted (bounded); returns just after the accept edge.
  task automatic push_req(input logic [IN_W-1:0] d, input logic [1:0] m,
                          input logic [SHAMT_W-1:0] sh);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_shamt = sh;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b101, 2'b00, 3'd0, 8'h05, 1'b0};
    vecs[1] = '{3'b101, 2'b01, 3'd0, 8'hFD, 1'b0};
    vecs[2] = '{3'b011, 2'b10, 3'd5, 8'h60, 1'b0};
    vecs[3] = '{3'b011, 2'b10, 3'd6, 8'hC0, 1'b1};
    vecs[4] = '{3'b111, 2'b10, 3'd7, 8'h80, 1'b0};
    vecs[5] = '{3'b101, 2'b11, 3'd0, 8'hA0, 1'b0};
    vecs[6] = '{3'b100, 2'b10, 3'd1, 8'hF8, 1'b0};
    vecs[7] = '{3'b100, 2'b10, 3'd6, 8'h00, 1'b1};
    vecs[8] = '{3'b011, 2'b11, 3'd0, 8'h60, 1'b0};
    vecs[9] = '{3'b010, 2'b01, 3'd0, 8'h02, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'b00;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b0;

    // Pin the model itself against hand-computed values.
    check("pin_sext", model_fn(3'b101, 2'b01, 3'd0).data, 8'hFD);
    check("pin_shl_ovf", model_fn(3'b011, 2'b10, 3'd6).ovf, 1);
    check("pin_upper", model_fn(3'b101, 2'b11, 3'd0).data, 8'hA0);

    // Initial reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    // Directed vectors, one at a time, held for a cycle before being popped
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      push_req(vecs[i].d, vecs[i].m, vecs[i].sh);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].want_data);
      check($sformatf("vec%0d_ovf", i), bus.out_ovf, vecs[i].want_ovf);
      check($sformatf("vec%0d_neg", i), bus.out_neg, vecs[i].want_data[OUT_W-1]);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
    end
    @(negedge clk);
    check("hold_after_pop_valid", bus.out_valid, 0);
    check("hold_after_pop_data", bus.out_data, 8'h02);

    // Backpressure: fill the buffer, hold a third request, then drain in order
    @(posedge clk);
    #1;
    push_req(3'b101, 2'b00, 3'd0);
    push_req(3'b101, 2'b01, 3'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 3'b011;
    bus.in_mode  = 2'b10;
    bus.in_shamt = 3'd5;
    repeat (3) begin
      @(negedge clk);
      check("bp_full_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_head0", bus.out_data, 8'h05);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_head1", bus.out_data, 8'hFD);
    check("bp_ready_back", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_head2", bus.out_data, 8'h60);
    check("bp_head2_valid", bus.out_valid, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_drained", bus.out_valid, 0);
    check("bp_hold_data", bus.out_data, 8'h60);

    // Streaming: one result per cycle, buffer never fills
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(i);
      bus.in_mode  = 2'(i);
      bus.in_shamt = SHAMT_W'(i * 3);
      @(negedge clk);
      check("stream_in_ready", bus.in_ready, 1);
      if (i > 0) check("stream_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", bus.out_valid, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("stream_done", bus.out_valid, 0);

    // Reset mid-traffic with two entries buffered
    @(posedge clk);
    #1;
    push_req(3'b111, 2'b01, 3'd0);
    push_req(3'b011, 2'b11, 3'd0);
    @(negedge clk);
    check("rst2_full", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst2_async_valid", bus.out_valid, 0);
    check("rst2_async_data", bus.out_data, 8'h00);
    check("rst2_async_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_release_ready", bus.in_ready, 1);
    check("rst2_release_valid", bus.out_valid, 0);
    check("rst2_release_data", bus.out_data, 8'h00);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
